seg_spi_tx: RTL
===============

# seg_spi_tx

Serializer that consumes the eight 7-bit seven-segment patterns produced by the Nios system's PIO exports and drives an external 8-digit MAX7219-style display over a 3-wire SPI link. After reset it runs a fixed configuration sequence. It then sends full 8-digit frames whenever any pattern changes and on a periodic refresh tick. Each pattern is snapshotted at frame start, converted to the driver's bit order, and shifted out as one 16-bit word per digit.

## Interface
Parameters:
- CLK_DIV, 4: clk_clk cycles per SCLK half-period (≥1).
- REFRESH_CYCLES, 50000: period of the refresh tick in clk_clk cycles (≥2).

Ports:
- clk_clk  input  1  system clock; one clock domain.
- reset_reset_n  input  1  asynchronous, active-low reset.
- seg0_in … seg7_in  input  7 each  active-low segment patterns; bit0=a … bit6=g. segN_in maps to digit register N+1.
- sclk  output  1  SPI clock; idles low.
- sdo  output  1  SPI data, MSB first.
- cs_n  output  1  chip select / load, active low.
- busy  output  1  high during the init sequence or a frame.
- frame_done  output  1  one-cycle pulse at the end of each 8-digit frame.

## Operation
- Reset values, applied immediately while reset_reset_n=0: sclk=0, sdo=0, cs_n=1, busy=0, frame_done=0. The FSM enters INIT, the snapshot clears to 0, and the refresh counter clears to 0.
- FSM states: INIT → IDLE ↔ FRAME.
  - INIT sends 5 words in order: 0x0900 (no decode), 0x0A08 (intensity), 0x0B07 (scan all 8), 0x0C01 (normal operation), 0x0F00 (test off).
  - After INIT the FSM goes to FRAME; the first frame is unconditional.
- Frame request (pend) is set by either of:
  - the refresh counter reaching REFRESH_CYCLES-1; the counter is free-running, wraps to 0, and is never gated.
  - any segN_in differing from the stored snapshot.
- IDLE with pend=1: the next cycle enters FRAME and clears pend. In the same cycle, all eight inputs are captured into the snapshot.
- FRAME sends digits 1..8 in order; word N = {4'h0, 4'(N), data byte}.
- Data byte = {1'b0, ~s[0], ~s[1], ~s[2], ~s[3], ~s[4], ~s[5], ~s[6]}, where s is the snapshot of seg(N-1)_in. This maps to DP=0, then A..G from D6 down to D0.
- Input changes during FRAME or INIT do not alter the word in flight. Because they differ from the snapshot, they set pend, so another frame follows.
- A refresh tick and a change detected in the same cycle produce a single pend.
- frame_done pulses in the cycle cs_n rises after the word for digit 8. It does not pulse after INIT.
- busy=1 from INIT entry until frame_done, and during every FRAME. busy falls in the cycle after frame_done.

## Timing
- Word transfer:
  - cs_n falls and sdo presents bit 15 in the same cycle.
  - Each bit occupies 2·CLK_DIV cycles: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - sdo changes only on the cycle sclk falls, or at cs_n fall for bit 15. The receiver samples on the sclk rising edge.
- After the high phase of bit 0, sclk returns low and cs_n rises in the same cycle. sdo returns to 0.
- cs_n stays high for 2·CLK_DIV cycles between words, including between INIT's last word and the first frame.
- Word period = 34·CLK_DIV cycles; with the default CLK_DIV=4 this is 136 cycles.
- Frame length = 8 word periods.
- Latency from an input change, with the FSM in IDLE:
  - cycle k: input changes.
  - cycle k+1: pend is set.
  - cycle k+2: FRAME entered and snapshot captured.
  - cycle k+2: cs_n falls, in the same cycle FRAME is entered.
- Asserting reset mid-word forces the outputs to their reset values asynchronously. After release the block restarts at INIT word 0; no partial word is resumed.

## Test plan
- Reset release with all inputs at 7'h7F and CLK_DIV=4:
  - required: five words 0x0900, 0x0A08, 0x0B07, 0x0C01, 0x0F00;
  - then eight words 0x0100 … 0x0800;
  - cs_n low 128 cycles per word, high 8 cycles between words;
  - frame_done pulses once.
- seg0_in=7'h40 ("0"), seg7_in=7'h79 ("1"), others 7'h7F:
  - required: digit 1 word 0x017E, digit 8 word 0x0830, others 0xN00.
- IDLE, then seg3_in changes 7'h7F→7'h24 ("2"):
  - required: cs_n falls exactly 2 cycles after the change;
  - digit 4 word 0x046D.
- REFRESH_CYCLES=2000 with stable inputs:
  - required: frames start at a fixed spacing of 2000 cycles;
  - every frame is identical.
- seg5_in changes while digit 2 of a frame is being sent:
  - required: the current frame carries the old seg5 value;
  - a second frame follows immediately with the new value;
  - two frame_done pulses.
- reset_reset_n pulled low at bit 7 of digit 4:
  - required: cs_n=1, sclk=0 and sdo=0 in the same cycle, without waiting for a clock edge;
  - after release the INIT sequence replays from 0x0900.

Source files
------------

// File: rtl/seg_spi_tx.sv
// seg_spi_tx: snapshots eight active-low seven-segment patterns and streams
// them to a MAX7219-style 8-digit driver over a 3-wire SPI link. A fixed
// five-word configuration runs after reset. After that a full frame is sent
// whenever a pattern changes or the free-running refresh tick fires.
module seg_spi_tx #(
   parameter int CLK_DIV        = 4,
   parameter int REFRESH_CYCLES = 50000
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic [6:0] seg0_in,
   input  logic [6:0] seg1_in,
   input  logic [6:0] seg2_in,
   input  logic [6:0] seg3_in,
   input  logic [6:0] seg4_in,
   input  logic [6:0] seg5_in,
   input  logic [6:0] seg6_in,
   input  logic [6:0] seg7_in,
   output logic       sclk,
   output logic       sdo,
   output logic       cs_n,
   output logic       busy,
   output logic       frame_done
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RW = $clog2(REFRESH_CYCLES);
   localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
   localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_FRAME
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [2:0]    idx;
   logic [2:0]    next_idx;

   logic [6:0]    seg_live [8];
   logic [6:0]    snap     [8];

   logic [RW-1:0] ref_cnt;
   logic          tick;
   logic          change;
   logic          pend;

   logic [PW-1:0] phase_cnt;
   logic [3:0]    bit_cnt;
   logic [15:0]   shreg;
   logic          in_gap;
   logic          gap_half;
   logic          launch;

   logic          phase_end;
   logic          word_end;
   logic          gap_end;
   logic          load_en;
   logic [15:0]   load_val;
   logic          capture;
   logic          start_gap;
   logic          set_done;

   assign seg_live[0] = seg0_in;
   assign seg_live[1] = seg1_in;
   assign seg_live[2] = seg2_in;
   assign seg_live[3] = seg3_in;
   assign seg_live[4] = seg4_in;
   assign seg_live[5] = seg5_in;
   assign seg_live[6] = seg6_in;
   assign seg_live[7] = seg7_in;

   // Configuration words: no decode, intensity 8, scan all digits, normal mode, test off.
   function automatic logic [15:0] init_word(input logic [2:0] i);
      case (i)
         3'd0:    init_word = 16'h0900;
         3'd1:    init_word = 16'h0A08;
         3'd2:    init_word = 16'h0B07;
         3'd3:    init_word = 16'h0C01;
         default: init_word = 16'h0F00;
      endcase
   endfunction

   // Digit register address i+1; segments are inverted to active-high, DP=0 then A..G.
   function automatic logic [15:0] digit_word(input logic [2:0] i, input logic [6:0] s);
      digit_word = {4'h0, {1'b0, i} + 4'd1,
                    1'b0, ~s[0], ~s[1], ~s[2], ~s[3], ~s[4], ~s[5], ~s[6]};
   endfunction

   assign phase_end = (phase_cnt == PHASE_LAST);
   assign word_end  = !cs_n && sclk && phase_end && (bit_cnt == 4'd0);
   assign gap_end   = in_gap && gap_half && phase_end;
   assign tick      = (ref_cnt == REF_LAST);

   // Any live input that differs from the frozen snapshot requests a new frame.
   always_comb begin
      change = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (seg_live[i] != snap[i]) change = 1'b1;
      end
   end

   // Next-state logic: decides which word to launch next and when frames start and end.
   always_comb begin
      next_state = state;
      next_idx   = idx;
      load_en    = 1'b0;
      load_val   = '0;
      capture    = 1'b0;
      start_gap  = 1'b0;
      set_done   = 1'b0;
      case (state)
         ST_INIT: begin
            if (launch) begin
               load_en  = 1'b1;
               load_val = init_word(idx);
            end else if (word_end) begin
               start_gap = 1'b1;
            end else if (gap_end) begin
               load_en = 1'b1;
               if (idx == 3'd4) begin
                  next_state = ST_FRAME;
                  next_idx   = 3'd0;
                  capture    = 1'b1;
                  load_val   = digit_word(3'd0, seg_live[0]);
               end else begin
                  next_idx = idx + 3'd1;
                  load_val = init_word(idx + 3'd1);
               end
            end
         end
         ST_IDLE: begin
            if (pend) begin
               next_state = ST_FRAME;
               next_idx   = 3'd0;
               capture    = 1'b1;
               load_en    = 1'b1;
               load_val   = digit_word(3'd0, seg_live[0]);
            end
         end
         ST_FRAME: begin
            if (frame_done) begin
               next_state = ST_IDLE;
            end else if (word_end) begin
               if (idx == 3'd7) set_done = 1'b1;
               else             start_gap = 1'b1;
            end else if (gap_end) begin
               next_idx = idx + 3'd1;
               load_en  = 1'b1;
               load_val = digit_word(idx + 3'd1, snap[idx + 3'd1]);
            end
         end
         default: begin
            next_state = ST_INIT;
            next_idx   = 3'd0;
         end
      endcase
   end

   // State register, word index and busy flag (busy drops the cycle after frame_done).
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state <= ST_INIT;
         idx   <= 3'd0;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         idx   <= next_idx;
         busy  <= (next_state != ST_IDLE);
      end
   end

   // Free-running refresh counter, pending-frame flag and input snapshot.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         ref_cnt <= '0;
         pend    <= 1'b0;
         for (int i = 0; i < 8; i++) snap[i] <= 7'h00;
      end else begin
         ref_cnt <= tick ? '0 : ref_cnt + RW'(1);
         if (capture) begin
            pend <= tick;
            for (int i = 0; i < 8; i++) snap[i] <= seg_live[i];
         end else if (tick || change) begin
            pend <= 1'b1;
         end
      end
   end

   // SPI word engine: 16 bits of low/high sclk phases, then a two-phase cs_n gap.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cs_n       <= 1'b1;
         sclk       <= 1'b0;
         sdo        <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= 4'd0;
         phase_cnt  <= '0;
         in_gap     <= 1'b0;
         gap_half   <= 1'b0;
         frame_done <= 1'b0;
         launch     <= 1'b1;
      end else begin
         launch     <= 1'b0;
         frame_done <= set_done;
         if (load_en) begin
            cs_n      <= 1'b0;
            sclk      <= 1'b0;
            sdo       <= load_val[15];
            shreg     <= {load_val[14:0], 1'b0};
            bit_cnt   <= 4'd15;
            phase_cnt <= '0;
            in_gap    <= 1'b0;
            gap_half  <= 1'b0;
         end else if (word_end) begin
            cs_n      <= 1'b1;
            sclk      <= 1'b0;
            sdo       <= 1'b0;
            phase_cnt <= '0;
            in_gap    <= start_gap;
            gap_half  <= 1'b0;
         end else if (!cs_n || in_gap) begin
            if (phase_end) begin
               phase_cnt <= '0;
               if (in_gap) begin
                  gap_half <= 1'b1;
               end else if (!sclk) begin
                  sclk <= 1'b1;
               end else begin
                  sclk    <= 1'b0;
                  sdo     <= shreg[15];
                  shreg   <= {shreg[14:0], 1'b0};
                  bit_cnt <= bit_cnt - 4'd1;
               end
            end else begin
               phase_cnt <= phase_cnt + PW'(1);
            end
         end
      end
   end

endmodule
